// File: rtl/display_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyphs (g..a) and
// the number of brightness phases per digit slot.
package display_pkg;

   localparam int PHASE_COUNT = 16;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph (bit 6 = g, bit 0 = a).
module seg7_hex_decode
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment scanner: per-frame input snapshot, leading-zero
// blanking, 16-phase brightness PWM and registered, glitch-free an/cat outputs.
module seg_display_scan
   import display_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int CLK_DIV = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp,
   input  logic                lz_blank,
   input  logic [3:0]          bright,
   output logic [DIGITS-1:0]   an,
   output logic [7:0]          cat,
   output logic                frame_start
);

   localparam int PHASE_LEN = CLK_DIV / PHASE_COUNT;
   localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SUB_W     = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
   localparam int IDX_W     = $clog2(DIGITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [DIV_W-1:0]    div_p0;
   logic [SUB_W-1:0]    sub_p0;
   logic [3:0]          phase_p0;
   logic [IDX_W-1:0]    idx_p0;

   logic [4*DIGITS-1:0] snap_value;
   logic [DIGITS-1:0]   snap_dp;
   logic                snap_lz;
   logic [3:0]          snap_bright;

   logic                capture;
   logic [4*DIGITS-1:0] eff_value;
   logic [DIGITS-1:0]   eff_dp;
   logic                eff_lz;
   logic [3:0]          eff_bright;
   logic [DIGITS-1:0]   blank;
   logic                zero_above;
   logic [3:0]          nib;
   logic [6:0]          glyph;
   logic                lit;
   logic [DIGITS-1:0]   an_next;
   logic [7:0]          cat_next;

   // The capture cycle already displays the freshly captured values, so the
   // first slot of every frame uses the same data as the rest of the frame.
   assign capture    = (div_p0 == '0) && (idx_p0 == '0);
   assign eff_value  = capture ? value    : snap_value;
   assign eff_dp     = capture ? dp       : snap_dp;
   assign eff_lz     = capture ? lz_blank : snap_lz;
   assign eff_bright = capture ? bright   : snap_bright;

   always_comb begin
      zero_above = 1'b1;
      blank      = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above & (eff_value[4*k +: 4] == 4'h0);
         if (k != 0) blank[k] = eff_lz & zero_above;
      end
   end

   assign nib = eff_value[{idx_p0, 2'b00} +: 4];

   seg7_hex_decode u_decode (
      .nibble (nib),
      .seg    (glyph)
   );

   assign lit = (phase_p0 < eff_bright);

   always_comb begin
      an_next  = '1;
      cat_next = 8'hFF;
      if (lit) begin
         an_next[idx_p0] = 1'b0;
         cat_next        = {~eff_dp[idx_p0], blank[idx_p0] ? SEG_BLANK : glyph};
      end
   end

   // p0 -> p1: counters advance, outputs register the decode of the current slot
   always_ff @(posedge clk) begin
      if (rst) begin
         div_p0      <= '0;
         sub_p0      <= '0;
         phase_p0    <= '0;
         idx_p0      <= '0;
         snap_value  <= '0;
         snap_dp     <= '0;
         snap_lz     <= 1'b0;
         snap_bright <= '0;
         an          <= '1;
         cat         <= 8'hFF;
         frame_start <= 1'b0;
      end else begin
         an          <= an_next;
         cat         <= cat_next;
         frame_start <= capture;
         if (capture) begin
            snap_value  <= value;
            snap_dp     <= dp;
            snap_lz     <= lz_blank;
            snap_bright <= bright;
         end
         if (div_p0 == DIV_LAST) begin
            div_p0   <= '0;
            sub_p0   <= '0;
            phase_p0 <= '0;
            idx_p0   <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
         end else begin
            div_p0 <= div_p0 + 1'b1;
            if (sub_p0 == SUB_LAST) begin
               sub_p0   <= '0;
               phase_p0 <= phase_p0 + 1'b1;
            end else begin
               sub_p0 <= sub_p0 + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan (4 digits, 16-cycle slots) against a frame-level
// reference model driven by directed and random stimulus.
module tb_seg_display_scan;

   localparam int SLOT  = 16;
   localparam int NDIG  = 4;
   localparam int FRAME = SLOT * NDIG;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        lz_blank;
   logic [3:0]  bright;
   logic [3:0]  an;
   logic [7:0]  cat;
   logic        frame_start;

   int errors = 0;
   int checks = 0;
   int k      = 0;

   logic [15:0] m_value;
   logic [3:0]  m_dp;
   logic        m_lz;
   logic [3:0]  m_bright;

   logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_display_scan #(.DIGITS(NDIG), .CLK_DIV(SLOT)) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .dp          (dp),
      .lz_blank    (lz_blank),
      .bright      (bright),
      .an          (an),
      .cat         (cat),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // One clock; outputs after edge k show the display for cycle k of the frame timeline.
   task automatic step();
      int          d;
      int          ph;
      logic        on;
      logic        blk;
      logic [3:0]  n;
      logic [3:0]  exp_an;
      logic [7:0]  exp_cat;
      @(posedge clk);
      #1;
      if (k % FRAME == 0) begin
         m_value  = value;
         m_dp     = dp;
         m_lz     = lz_blank;
         m_bright = bright;
      end
      d   = (k / SLOT) % NDIG;
      ph  = k % SLOT;
      on  = (ph < int'(m_bright));
      blk = m_lz && (d >= 1) && ((m_value >> (4 * d)) == 16'h0);
      n   = 4'(m_value >> (4 * d));
      exp_an  = on ? ~(4'b0001 << d) : 4'hF;
      exp_cat = on ? {~m_dp[d], blk ? 7'h7F : glyph_tab[n]} : 8'hFF;
      chk("an", {4'h0, an}, {4'h0, exp_an});
      chk("cat", cat, exp_cat);
      chk("frame_start", {7'h0, frame_start}, {7'h0, (k % FRAME) == 0});
      k++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until(input int m);
      for (int i = 0; i < FRAME && (k % FRAME) != m; i++) step();
   endtask

   task automatic reset_pulse(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) @(posedge clk);
      #1;
      chk("rst_an", {4'h0, an}, 8'h0F);
      chk("rst_cat", cat, 8'hFF);
      chk("rst_frame_start", {7'h0, frame_start}, 8'h00);
      rst = 1'b0;
      k   = 0;
   endtask

   initial begin
      int lit_cnt;
      rst      = 1'b1;
      value    = 16'h12AF;
      dp       = 4'b0000;
      lz_blank = 1'b0;
      bright   = 4'd15;
      #2;
      reset_pulse(2);

      // Basic scan over two frames.
      steps(2 * FRAME);

      // Leading-zero blanking.
      value    = 16'h0050;
      lz_blank = 1'b1;
      steps(2 * FRAME);

      // All-zero value with a lone decimal point on a blanked digit.
      value = 16'h0000;
      dp    = 4'b0100;
      steps(FRAME);
      run_until(0);

      // Brightness 4: count lit cycles across one frame.
      dp      = 4'b0000;
      bright  = 4'd4;
      lit_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (an !== 4'hF) lit_cnt++;
      end
      chk("lit_count_b4", 8'(lit_cnt), 8'd16);

      // Brightness 0: dark frame.
      bright = 4'd0;
      steps(FRAME);

      // Mid-frame value change must wait for the next frame.
      bright   = 4'd15;
      value    = 16'h1111;
      lz_blank = 1'b0;
      run_until(0);
      run_until(20);
      value = 16'h2222;
      run_until(30);
      step();
      chk("midframe_old", cat, 8'hF9);
      run_until(30);
      step();
      chk("nextframe_new", cat, 8'hA4);

      // Reset mid-frame.
      run_until(37);
      bright = 4'd6;
      value  = 16'h0F3C;
      reset_pulse(1);
      steps(FRAME + 8);

      // Random inputs changed at random cycles.
      for (int i = 0; i < 6 * FRAME; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: value = 16'($urandom);
               1: value = 16'($urandom) & 16'h00FF;
               2: value = 16'($urandom) & 16'h000F;
               default: value = 16'h0000;
            endcase
            dp       = 4'($urandom);
            lz_blank = 1'($urandom);
            bright   = 4'($urandom);
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
